// File: rtl/touch_region_colour_pkg.sv
// Shared types and constants for the touch-to-colour path of the 800x480 LTM.
package touch_region_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ACCEPT,
        HOLDOFF,
        WAIT_RELEASE
    } filter_state_t;

    localparam int NUM_REGIONS = 8;
    localparam int CODE_W      = 3;
    localparam int LCD_W       = 800;
    localparam int LCD_H       = 480;

    typedef logic [CODE_W-1:0] code_t;
    typedef logic [2:0]        region_t;

endpackage

// File: rtl/touch_region_colour_if.sv
// Touch panel and LCD pixel signals shared by the controllers and touch_region_colour.
interface touch_region_colour_if;
    import touch_region_pkg::*;

    logic        Touch_En;
    logic        Coord_En;
    logic [11:0] X_Coord;
    logic [11:0] Y_Coord;
    logic [9:0]  Pixel_X;
    logic [9:0]  Pixel_Y;
    logic [7:0]  Red;
    logic [7:0]  Green;
    logic [7:0]  Blue;
    logic        Touch_Pulse;
    region_t     Region_Sel;
    logic        Busy;

    modport master (
        output Touch_En, Coord_En, X_Coord, Y_Coord, Pixel_X, Pixel_Y,
        input  Red, Green, Blue, Touch_Pulse, Region_Sel, Busy
    );

    modport slave (
        input  Touch_En, Coord_En, X_Coord, Y_Coord, Pixel_X, Pixel_Y,
        output Red, Green, Blue, Touch_Pulse, Region_Sel, Busy
    );

endinterface

// File: rtl/touch_region_colour_filter.sv
// Turns raw Coord_En strobes into single accepted touch events (edge detect + hold-off).
// Define TOUCH_RELEASE_WAIT_EN to also wait for pen release before re-arming.
module touch_event_filter
    import touch_region_pkg::*;
#(
    parameter int HOLDOFF_CYCLES = 2500000
) (
    input  logic    Clock,
    input  logic    Resetn,
    input  logic    Coord_En,
    input  logic    Touch_En,
    input  region_t touch_region,
    output logic    accept,
    output region_t accept_region,
    output region_t Region_Sel,
    output logic    Busy
);

    localparam int CNT_W = (HOLDOFF_CYCLES > 1) ? $clog2(HOLDOFF_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(HOLDOFF_CYCLES - 1);

    filter_state_t    state_q, state_d;
    logic             coord_d;
    logic [CNT_W-1:0] cnt_q;
    logic             candidate;

    assign candidate     = Coord_En & ~coord_d;
    assign accept        = (state_q == ACCEPT);
    assign Busy          = (state_q != IDLE);

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) state_q <= IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (candidate) state_d = ACCEPT;
            ACCEPT:  state_d = HOLDOFF;
`ifdef TOUCH_RELEASE_WAIT_EN
            HOLDOFF: if (cnt_q == '0) state_d = WAIT_RELEASE;
            WAIT_RELEASE: if (!Touch_En) state_d = IDLE;
`else
            HOLDOFF: if (cnt_q == '0) state_d = IDLE;
`endif
            default: state_d = IDLE;
        endcase
    end

`ifndef TOUCH_RELEASE_WAIT_EN
    logic touch_en_unused;
    assign touch_en_unused = Touch_En;
`endif

    // Delay register resets high so a level already present at reset release is not an edge.
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            coord_d       <= 1'b1;
            cnt_q         <= '0;
            accept_region <= '0;
            Region_Sel    <= '0;
        end else begin
            coord_d <= Coord_En;
            if (state_q == IDLE && candidate)
                accept_region <= touch_region;
            if (state_q == ACCEPT) begin
                cnt_q      <= CNT_LOAD;
                Region_Sel <= accept_region;
            end else if (state_q == HOLDOFF && cnt_q != '0) begin
                cnt_q <= cnt_q - 1'b1;
            end
        end
    end

endmodule

// File: rtl/touch_region_colour.sv
// Per-region colour codes advanced by filtered touches, plus the 1-cycle pixel colour lookup.
module touch_region_colour
    import touch_region_pkg::*;
#(
    parameter int HOLDOFF_CYCLES = 2500000,
    parameter int Y_SPLIT        = 240,
    parameter int COL_WIDTH      = 200
) (
    input  logic                  Clock,
    input  logic                  Resetn,
    touch_region_colour_if.slave  bus
);

    localparam logic [9:0] COL1 = 10'(COL_WIDTH);
    localparam logic [9:0] COL2 = 10'(2 * COL_WIDTH);
    localparam logic [9:0] COL3 = 10'(3 * COL_WIDTH);
    localparam logic [9:0] ROW1 = 10'(Y_SPLIT);

    logic        accept;
    region_t     accept_region;
    region_t     pix_region;
    logic [1:0]  pix_col;
    code_t       pix_code;
    code_t       colour_q [NUM_REGIONS];
    logic [20:0] coord_bits_unused;

    assign coord_bits_unused = {bus.X_Coord[9:0], bus.Y_Coord[10:0]};

    touch_event_filter #(
        .HOLDOFF_CYCLES (HOLDOFF_CYCLES)
    ) u_filter (
        .Clock         (Clock),
        .Resetn        (Resetn),
        .Coord_En      (bus.Coord_En),
        .Touch_En      (bus.Touch_En),
        .touch_region  ({bus.Y_Coord[11], bus.X_Coord[11:10]}),
        .accept        (accept),
        .accept_region (accept_region),
        .Region_Sel    (bus.Region_Sel),
        .Busy          (bus.Busy)
    );

    assign bus.Touch_Pulse = accept;

    // Column by comparison against the region edges; anything past the third edge is column 3.
    always_comb begin
        pix_col = 2'd0;
        if      (bus.Pixel_X >= COL3) pix_col = 2'd3;
        else if (bus.Pixel_X >= COL2) pix_col = 2'd2;
        else if (bus.Pixel_X >= COL1) pix_col = 2'd1;
    end

    assign pix_region = {bus.Pixel_Y >= ROW1, pix_col};
    assign pix_code   = colour_q[pix_region];

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            for (int i = 0; i < NUM_REGIONS; i++)
                colour_q[i] <= code_t'(i);
        end else if (accept) begin
            colour_q[accept_region] <= colour_q[accept_region] + 1'b1;
        end
    end

    // Reads the pre-update code, so a lookup during ACCEPT still sees the old colour.
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            bus.Red   <= '0;
            bus.Green <= '0;
            bus.Blue  <= '0;
        end else begin
            bus.Red   <= {8{pix_code[0]}};
            bus.Blue  <= {8{pix_code[1]}};
            bus.Green <= {8{pix_code[2]}};
        end
    end

endmodule

// File: tb/tb_touch_region_colour.sv
// Self-checking bench for touch_region_colour; honours TOUCH_RELEASE_WAIT_EN when defined.
module tb_touch_region_colour;

    localparam int H = 16;

    logic Clock = 1'b0;
    logic Resetn;

    touch_region_colour_if bus_if ();

    touch_region_colour #(
        .HOLDOFF_CYCLES (H)
    ) dut (
        .Clock  (Clock),
        .Resetn (Resetn),
        .bus    (bus_if)
    );

    always #5 Clock = ~Clock;

    int checks = 0;
    int errors = 0;

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Reference model: colour codes per region and time-based filter availability.
    int m_code [8];
    int cyc = 0;
    int free_at = 0;
    int wait_from = 0;
    bit waiting = 0;
    bit coord_prev = 1;
    bit pend = 0;
    int pend_idx = 0;
    int exp_r = 0, exp_g = 0, exp_b = 0, exp_pulse = 0, exp_sel = 0, exp_busy = 0;
    int code_now;

    function automatic int pixelRegion(input int px, input int py);
        int col;
        col = px / 200;
        if (col > 3) col = 3;
        return ((py >= 240) ? 4 : 0) + col;
    endfunction

    function automatic int touchRegion(input int x, input int y);
        return ((y >> 11) & 1) * 4 + ((x >> 10) & 3);
    endfunction

    always @(posedge Clock) begin
        if (!Resetn) begin
            for (int i = 0; i < 8; i++) m_code[i] = i;
            coord_prev = 1; free_at = 0; waiting = 0; pend = 0; pend_idx = 0;
            exp_r = 0; exp_g = 0; exp_b = 0; exp_pulse = 0; exp_sel = 0; exp_busy = 0;
        end else begin
            code_now = m_code[pixelRegion(int'(bus_if.Pixel_X), int'(bus_if.Pixel_Y))];
            exp_r = (code_now & 1) ? 255 : 0;
            exp_b = (code_now & 2) ? 255 : 0;
            exp_g = (code_now & 4) ? 255 : 0;
            if (pend) begin
                m_code[pend_idx] = (m_code[pend_idx] + 1) % 8;
                exp_sel = pend_idx;
            end
            pend = 0;
            exp_pulse = 0;
`ifdef TOUCH_RELEASE_WAIT_EN
            if (waiting && cyc >= wait_from && !bus_if.Touch_En) begin
                free_at = cyc + 1;
                waiting = 0;
            end
`endif
            if (bus_if.Coord_En && !coord_prev && cyc >= free_at) begin
                pend = 1;
                pend_idx = touchRegion(int'(bus_if.X_Coord), int'(bus_if.Y_Coord));
                exp_pulse = 1;
`ifdef TOUCH_RELEASE_WAIT_EN
                free_at = 32'h7fffffff;
                waiting = 1;
                wait_from = cyc + 2 + H;
`else
                free_at = cyc + 2 + H;
`endif
            end
            coord_prev = bus_if.Coord_En;
            exp_busy = (cyc + 1 < free_at) ? 1 : 0;
        end
        cyc++;
        #1;
        checkOutput("red", int'(bus_if.Red), exp_r);
        checkOutput("green", int'(bus_if.Green), exp_g);
        checkOutput("blue", int'(bus_if.Blue), exp_b);
        checkOutput("touch_pulse", int'(bus_if.Touch_Pulse), exp_pulse);
        checkOutput("region_sel", int'(bus_if.Region_Sel), exp_sel);
        checkOutput("busy", int'(bus_if.Busy), exp_busy);
    end

    task automatic applyStimulus(input bit coord_en, input bit touch_en, input int x, input int y);
        bus_if.Coord_En = coord_en;
        bus_if.Touch_En = touch_en;
        bus_if.X_Coord  = 12'(x);
        bus_if.Y_Coord  = 12'(y);
    endtask

    task automatic setPixel(input int px, input int py);
        bus_if.Pixel_X = 10'(px);
        bus_if.Pixel_Y = 10'(py);
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge Clock);
    endtask

    int sx [11] = '{199, 200, 399, 400, 599, 600, 799, 199, 200, 600, 0};
    int sy [11] = '{239, 239, 239, 239, 239, 239, 239, 240, 240, 479, 479};

    initial begin
        Resetn = 1'b0;
        applyStimulus(1, 1, 0, 0);
        setPixel(0, 0);
        tick(3);

        $display("[TB] reset release with Coord_En high");
        Resetn = 1'b1;
        tick(1);
        checkOutput("lit_no_pulse_at_release", int'(bus_if.Touch_Pulse), 0);
        checkOutput("lit_rgb_0_0", int'({bus_if.Red, bus_if.Green, bus_if.Blue}), 0);
        setPixel(799, 479);
        tick(1);
        checkOutput("lit_rgb_799_479", int'({bus_if.Red, bus_if.Green, bus_if.Blue}), 24'hFFFFFF);
        tick(3);
        checkOutput("lit_idle_busy", int'(bus_if.Busy), 0);

        $display("[TB] touch in region 1 with same-region lookup");
        applyStimulus(0, 0, 0, 0);
        tick(1);
        applyStimulus(1, 0, 12'h500, 12'h000);
        setPixel(250, 10);
        tick(1);
        checkOutput("lit_pulse_accept", int'(bus_if.Touch_Pulse), 1);
        checkOutput("lit_red_edge_cycle", int'(bus_if.Red), 8'hFF);
        applyStimulus(0, 0, 12'h500, 12'h000);
        tick(1);
        checkOutput("lit_pulse_one_cycle", int'(bus_if.Touch_Pulse), 0);
        checkOutput("lit_region_sel_1", int'(bus_if.Region_Sel), 1);
        checkOutput("lit_red_old_code", int'(bus_if.Red), 8'hFF);
        checkOutput("lit_blue_old_code", int'(bus_if.Blue), 0);
        tick(1);
        checkOutput("lit_red_new_code", int'(bus_if.Red), 0);
        checkOutput("lit_green_new_code", int'(bus_if.Green), 0);
        checkOutput("lit_blue_new_code", int'(bus_if.Blue), 8'hFF);
        tick(20);

        $display("[TB] edge during hold-off, then after hold-off");
        applyStimulus(1, 0, 12'h800, 12'h000);
        tick(1);
        checkOutput("lit_pulse_region2", int'(bus_if.Touch_Pulse), 1);
        applyStimulus(0, 0, 12'h800, 12'h000);
        tick(10);
        applyStimulus(1, 0, 12'h800, 12'h000);
        tick(1);
        checkOutput("lit_holdoff_ignored", int'(bus_if.Touch_Pulse), 0);
        checkOutput("lit_holdoff_busy", int'(bus_if.Busy), 1);
        applyStimulus(0, 0, 12'h800, 12'h000);
        tick(10);
        applyStimulus(1, 0, 12'h800, 12'h000);
        tick(1);
        checkOutput("lit_after_holdoff", int'(bus_if.Touch_Pulse), 1);
        applyStimulus(0, 0, 12'h800, 12'h000);
        tick(20);

        $display("[TB] eight touches in region 7");
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1, 0, 12'hC00, 12'h800);
            tick(1);
            applyStimulus(0, 0, 12'hC00, 12'h800);
            setPixel(700, 300);
            tick(19);
            if (i == 0)
                checkOutput("lit_region7_wrap", int'({bus_if.Red, bus_if.Green, bus_if.Blue}), 0);
        end
        setPixel(799, 479);
        tick(1);
        checkOutput("lit_region7_back", int'({bus_if.Red, bus_if.Green, bus_if.Blue}), 24'hFFFFFF);
        checkOutput("model_code7", m_code[7], 7);
        checkOutput("model_code1", m_code[1], 2);
        checkOutput("model_code2", m_code[2], 4);

        $display("[TB] held pen with repeated strobes in region 5");
        for (int s = 0; s < 3; s++) begin
            applyStimulus(1, 1, 12'h400, 12'h800);
            tick(1);
`ifdef TOUCH_RELEASE_WAIT_EN
            checkOutput("lit_held_pen_pulse", int'(bus_if.Touch_Pulse), (s == 0) ? 1 : 0);
`else
            checkOutput("lit_held_pen_pulse", int'(bus_if.Touch_Pulse), 1);
`endif
            applyStimulus(0, 1, 12'h400, 12'h800);
            tick(19);
        end
`ifdef TOUCH_RELEASE_WAIT_EN
        checkOutput("lit_wait_release_busy", int'(bus_if.Busy), 1);
`endif
        applyStimulus(0, 0, 12'h400, 12'h800);
        tick(3);
        checkOutput("lit_released_idle", int'(bus_if.Busy), 0);

        $display("[TB] pixel boundary sweep");
        setPixel(199, 239);
        tick(1);
        checkOutput("lit_x199_blue", int'(bus_if.Blue), 0);
        setPixel(200, 239);
        tick(1);
        checkOutput("lit_x200_blue", int'(bus_if.Blue), 8'hFF);
        for (int i = 0; i < 11; i++) begin
            setPixel(sx[i], sy[i]);
            tick(1);
        end

        $display("[TB] reset during hold-off");
        applyStimulus(1, 0, 12'h500, 12'h000);
        tick(1);
        applyStimulus(0, 0, 12'h500, 12'h000);
        tick(3);
        Resetn = 1'b0;
        #1;
        checkOutput("lit_reset_busy", int'(bus_if.Busy), 0);
        checkOutput("lit_reset_region_sel", int'(bus_if.Region_Sel), 0);
        tick(2);
        Resetn = 1'b1;
        setPixel(250, 10);
        tick(1);
        checkOutput("lit_reset_code1", int'({bus_if.Red, bus_if.Green, bus_if.Blue}), 24'hFF0000);
        tick(2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
